// File: rtl/filter_conv_engine.sv
// 4-tap causal Q8.8 convolution engine with one shared multiplier (4 cycles per output).
// Optional macro TAIL_FLUSH_EN: after the last input, run 3 zero-input rounds (N+3 outputs).
module filter_conv_engine #(
  parameter int FRAC_BITS     = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int OUT_BASE_ADDR = 0
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  en,
  input  logic                  b_element_ready,
  input  logic [15:0]           b0_element,
  input  logic [15:0]           b1_element,
  input  logic [15:0]           b2_element,
  input  logic [15:0]           b3_element,
  output logic                  m_element_requested,
  input  logic                  m_element_ready,
  input  logic [15:0]           m_element,
  input  logic                  last_m_element,
  output logic [ADDR_WIDTH-1:0] out_memory_address,
  output logic                  out_memory_enable,
  output logic                  out_memory_write,
  output logic [15:0]           out_element,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE, LOAD_B, REQ, WAIT_M, MAC, WRITE, DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(OUT_BASE_ADDR);
  localparam logic signed [33:0]    ROUND   = 34'sd1 <<< (FRAC_BITS - 1);
  localparam logic signed [33:0]    SAT_MAX = 34'sd32767;
  localparam logic signed [33:0]    SAT_MIN = -34'sd32768;

  state_t state, state_next;

  logic signed [15:0]     b0_q, b1_q, b2_q, b3_q;
  logic signed [15:0]     x0, x1, x2, x3;
  logic signed [33:0]     acc;
  logic [ADDR_WIDTH-1:0]  index;
  logic [1:0]             tap;
  logic                   last_q;
  logic                   flush_more;

  logic signed [15:0]     tap_b, tap_x;
  logic signed [31:0]     prod;
  logic signed [33:0]     rounded, shifted;
  logic [15:0]            sat_val;

`ifdef TAIL_FLUSH_EN
  logic [1:0] flush_cnt;
  assign flush_more = (flush_cnt != 2'd3);
`else
  assign flush_more = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_next;
  end

  // Handshake: the request is a one-cycle pulse issued in REQ; the manager answers
  // with a one-cycle m_element_ready (data valid that cycle), honoured only in WAIT_M.
  // WAIT_M ignores en so a ready pulse arriving during a stall is never lost.
  always_comb begin
    state_next          = state;
    m_element_requested = 1'b0;
    out_memory_enable   = 1'b0;
    out_memory_write    = 1'b0;
    case (state)
      IDLE:   if (en && b_element_ready) state_next = LOAD_B;
      LOAD_B: if (en) state_next = REQ;
      REQ: begin
        if (en) begin
          m_element_requested = 1'b1;
          state_next          = WAIT_M;
        end
      end
      WAIT_M: if (m_element_ready) state_next = MAC;
      MAC:    if (en && tap == 2'd3) state_next = WRITE;
      WRITE: begin
        if (en) begin
          out_memory_enable = 1'b1;
          out_memory_write  = 1'b1;
          if (!last_q)         state_next = REQ;
          else if (flush_more) state_next = MAC;
          else                 state_next = DONE;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tap_b = b0_q;
    tap_x = x0;
    case (tap)
      2'd1: begin tap_b = b1_q; tap_x = x1; end
      2'd2: begin tap_b = b2_q; tap_x = x2; end
      2'd3: begin tap_b = b3_q; tap_x = x3; end
      default: ;
    endcase
  end

  assign prod    = tap_b * tap_x;
  assign rounded = acc + ROUND;
  assign shifted = rounded >>> FRAC_BITS;

  always_comb begin
    sat_val = shifted[15:0];
    if (shifted > SAT_MAX)      sat_val = 16'h7FFF;
    else if (shifted < SAT_MIN) sat_val = 16'h8000;
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      b0_q   <= '0;
      b1_q   <= '0;
      b2_q   <= '0;
      b3_q   <= '0;
      x0     <= '0;
      x1     <= '0;
      x2     <= '0;
      x3     <= '0;
      acc    <= '0;
      index  <= '0;
      tap    <= '0;
      last_q <= 1'b0;
`ifdef TAIL_FLUSH_EN
      flush_cnt <= '0;
`endif
    end else begin
      case (state)
        LOAD_B: begin
          if (en) begin
            b0_q   <= b0_element;
            b1_q   <= b1_element;
            b2_q   <= b2_element;
            b3_q   <= b3_element;
            x0     <= '0;
            x1     <= '0;
            x2     <= '0;
            x3     <= '0;
            index  <= '0;
            last_q <= 1'b0;
`ifdef TAIL_FLUSH_EN
            flush_cnt <= '0;
`endif
          end
        end
        WAIT_M: begin
          if (m_element_ready) begin
            x0     <= m_element;
            last_q <= last_m_element;
            acc    <= '0;
            tap    <= '0;
          end
        end
        MAC: begin
          if (en) begin
            acc <= acc + {{2{prod[31]}}, prod};
            tap <= tap + 2'd1;
          end
        end
        WRITE: begin
          if (en) begin
            x3    <= x2;
            x2    <= x1;
            x1    <= x0;
            index <= index + 1'b1;
`ifdef TAIL_FLUSH_EN
            // Flush rounds feed zeros through the delay line without a request.
            if (last_q && flush_more) begin
              x0        <= '0;
              acc       <= '0;
              tap       <= '0;
              flush_cnt <= flush_cnt + 2'd1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign out_memory_address = (state == WRITE) ? BASE + index : '0;
  assign out_element        = (state == WRITE) ? sat_val : '0;
  assign busy               = (state != IDLE) && (state != DONE);
  assign done               = (state == DONE);

endmodule

// File: tb/tb_filter_conv_engine.sv
// Directed bench for filter_conv_engine: a convolution model computes each expected
// write; a negedge compare process checks every strobe against the expected queue.
module tb_filter_conv_engine;

  localparam int ADDR_WIDTH    = 10;
  localparam int OPT_NONE      = 0;
  localparam int OPT_MAC_STALL = 1;
  localparam int OPT_WAIT_EN   = 2;
  localparam int OPT_SPURIOUS  = 3;
  localparam int OPT_STALL_REQ = 4;

  logic                  clock = 1'b0;
  logic                  clear_n = 1'b0;
  logic                  en = 1'b0;
  logic                  b_element_ready = 1'b0;
  logic [15:0]           b0_element = '0, b1_element = '0, b2_element = '0, b3_element = '0;
  logic                  m_element_requested;
  logic                  m_element_ready = 1'b0;
  logic [15:0]           m_element = '0;
  logic                  last_m_element = 1'b0;
  logic [ADDR_WIDTH-1:0] out_memory_address;
  logic                  out_memory_enable;
  logic                  out_memory_write;
  logic [15:0]           out_element;
  logic                  busy;
  logic                  done;

  filter_conv_engine #(.FRAC_BITS(8), .ADDR_WIDTH(ADDR_WIDTH), .OUT_BASE_ADDR(0)) dut (
    .clock(clock), .clear_n(clear_n), .en(en), .b_element_ready(b_element_ready),
    .b0_element(b0_element), .b1_element(b1_element), .b2_element(b2_element),
    .b3_element(b3_element), .m_element_requested(m_element_requested),
    .m_element_ready(m_element_ready), .m_element(m_element),
    .last_m_element(last_m_element), .out_memory_address(out_memory_address),
    .out_memory_enable(out_memory_enable), .out_memory_write(out_memory_write),
    .out_element(out_element), .busy(busy), .done(done)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [ADDR_WIDTH+15:0] exp_q[$];
  logic [15:0] wr_log[$];
  int req_count = 0;
  int write_count = 0;

  int mb[4];
  int mx[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // y[n] = sum b_k * x[n-k], round half up at bit 7, shift by 8, saturate to 16 bits.
  function automatic logic [15:0] model_y(int n);
    longint acc;
    acc = 0;
    for (int k = 0; k < 4; k++)
      if (n - k >= 0 && n - k < mx.size())
        acc += longint'(mb[k]) * longint'(mx[n - k]);
    acc = (acc + 128) >>> 8;
    if (acc > 32767)  return 16'h7FFF;
    if (acc < -32768) return 16'h8000;
    return acc[15:0];
  endfunction

  always @(negedge clock) begin
    logic [ADDR_WIDTH+15:0] e;
    if (clear_n) begin
      if (m_element_requested) req_count++;
      if (!en)
        check("stall_quiet", {29'd0, m_element_requested, out_memory_enable, out_memory_write}, 32'd0);
      if (out_memory_enable || out_memory_write) begin
        write_count++;
        check("strobe_pair", {31'd0, out_memory_enable}, {31'd0, out_memory_write});
        wr_log.push_back(out_element);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h with empty queue", out_memory_address, out_element);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(out_memory_address), 32'(e[ADDR_WIDTH+15:16]));
          check("wr_data", 32'(out_element), 32'(e[15:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    en = 1'b0;
    b_element_ready = 1'b0;
    m_element_ready = 1'b0;
    last_m_element = 1'b0;
    tick();
    tick();
    check("reset_outputs", {1'b0, m_element_requested, out_memory_enable, out_memory_write,
                            out_memory_address, out_element, busy, done}, 32'd0);
    clear_n = 1'b1;
  endtask

  task automatic set_taps(input logic [15:0] t0, input logic [15:0] t1,
                          input logic [15:0] t2, input logic [15:0] t3);
    mb[0] = int'($signed(t0));
    mb[1] = int'($signed(t1));
    mb[2] = int'($signed(t2));
    mb[3] = int'($signed(t3));
    mx.delete();
  endtask

  task automatic add_x(input logic [15:0] v);
    mx.push_back(int'($signed(v)));
  endtask

  task automatic feed(input int i, input bit last, input int delay, input int opt);
    int n;
    int t_ready;
    int exp_lat;
    n = 0;
    while (!m_element_requested && n < 200) begin tick(); n++; end
    if (!m_element_requested) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: no request for element %0d", i);
      return;
    end
    repeat (delay) tick();
    exp_q.push_back({ADDR_WIDTH'(i), model_y(i)});
    m_element = 16'(mx[i]);
    last_m_element = last;
    m_element_ready = 1'b1;
    if (opt == OPT_WAIT_EN) en = 1'b0;
    t_ready = cyc;
    tick();
    m_element_ready = 1'b0;
    last_m_element = 1'b0;
    m_element = 16'hDEAD;
    exp_lat = 5;
    case (opt)
      OPT_WAIT_EN: begin tick(); en = 1'b1; exp_lat = 6; end
      OPT_MAC_STALL: begin en = 1'b0; repeat (3) tick(); en = 1'b1; exp_lat = 8; end
      OPT_SPURIOUS: begin
        m_element_ready = 1'b1; m_element = 16'h7777; last_m_element = 1'b1;
        tick();
        m_element_ready = 1'b0; last_m_element = 1'b0;
      end
      default: ;
    endcase
    n = 0;
    while (!out_memory_enable && n < 50) begin tick(); n++; end
    check("write_latency", 32'(cyc - t_ready), 32'(exp_lat));
    if (opt == OPT_SPURIOUS) begin
      m_element_ready = 1'b1; m_element = 16'h6666;
      tick();
      m_element_ready = 1'b0;
    end
    if (opt == OPT_STALL_REQ && !last) begin
      tick();
      en = 1'b0;
      tick();
      tick();
      en = 1'b1;
      #1;
    end
  endtask

  task automatic run_vector(input bit with_reset, input int delay, input int opt_idx, input int opt);
    int n_el;
    int n_out;
    int n;
    int t;
    n_el = mx.size();
    n_out = n_el;
    if (with_reset) do_reset();
    exp_q.delete();
    wr_log.delete();
    req_count = 0;
    write_count = 0;
    en = 1'b1;
    b0_element = 16'(mb[0]);
    b1_element = 16'(mb[1]);
    b2_element = 16'(mb[2]);
    b3_element = 16'(mb[3]);
    b_element_ready = 1'b1;
    tick();
    tick();
    // Taps were latched in LOAD_B; later changes must not matter.
    b0_element = 16'h5A5A; b1_element = 16'hA5A5; b2_element = 16'h1234; b3_element = 16'h4321;
    for (int i = 0; i < n_el; i++)
      feed(i, i == n_el - 1, delay, (i == opt_idx) ? opt : OPT_NONE);
`ifdef TAIL_FLUSH_EN
    n_out = n_el + 3;
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back({ADDR_WIDTH'(n_el + f), model_y(n_el + f)});
      t = cyc;
      tick();
      n = 0;
      while (!out_memory_enable && n < 50) begin tick(); n++; end
      check("flush_latency", 32'(cyc - t), 32'd5);
    end
`endif
    repeat (2) tick();
    check("done_flag", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("request_count", 32'(req_count), 32'(n_el));
    check("write_count", 32'(write_count), 32'(n_out));
    m_element_ready = 1'b1;
    m_element = 16'h1111;
    tick();
    m_element_ready = 1'b0;
    repeat (6) tick();
    check("done_ignores_ready", 32'(write_count), 32'(n_out));
    check("done_held", {31'd0, done}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    do_reset();

    // Hand-computed pins on the model itself.
    set_taps(16'h0040, 16'h0040, 16'h0040, 16'h0040);
    repeat (4) add_x(16'h0400);
    check("pin_ma_y0", 32'(model_y(0)), 32'h0100);
    check("pin_ma_y3", 32'(model_y(3)), 32'h0400);
    check("pin_ma_y4", 32'(model_y(4)), 32'h0300);
    set_taps(16'h0080, 16'h0000, 16'h0000, 16'h0000);
    add_x(16'h0001);
    check("pin_round", 32'(model_y(0)), 32'h0001);

    // Identity filter.
    set_taps(16'h0100, 16'h0000, 16'h0000, 16'h0000);
    add_x(16'h0200);
    add_x(16'h0300);
    run_vector(1'b1, 1, -1, OPT_NONE);
    check("ident_y0", 32'(wr_log[0]), 32'h0200);
    check("ident_y1", 32'(wr_log[1]), 32'h0300);

    // Moving average with a slow manager (ready 20 cycles after the request).
    set_taps(16'h0040, 16'h0040, 16'h0040, 16'h0040);
    repeat (4) add_x(16'h0400);
    run_vector(1'b1, 20, -1, OPT_NONE);
    check("ma_y3", 32'(wr_log[3]), 32'h0400);
`ifdef TAIL_FLUSH_EN
    check("ma_flush_y6", 32'(wr_log[6]), 32'h0100);
`endif

    // Saturation and rounding.
    set_taps(16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
    add_x(16'h7FFF);
    run_vector(1'b1, 1, -1, OPT_NONE);
    check("sat_pos", 32'(wr_log[0]), 32'h7FFF);
    set_taps(16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
    add_x(16'h8000);
    run_vector(1'b1, 2, -1, OPT_NONE);
    check("sat_neg", 32'(wr_log[0]), 32'h8000);
    set_taps(16'h0080, 16'h0000, 16'h0000, 16'h0000);
    add_x(16'h0001);
    run_vector(1'b1, 1, -1, OPT_NONE);
    check("round_half_up", 32'(wr_log[0]), 32'h0001);

    // Mixed-sign taps under the various stall and robustness scenarios.
    for (int opt = OPT_MAC_STALL; opt <= OPT_STALL_REQ; opt++) begin
      set_taps(16'h0100, 16'hFF80, 16'h0020, 16'hFFF0);
      add_x(16'h0300);
      add_x(16'hFD00);
      add_x(16'h0180);
      add_x(16'h0040);
      run_vector(1'b1, 1, 1, opt);
    end

    // Reset in the middle of MAC aborts; a fresh run starts from address 0.
    do_reset();
    en = 1'b1;
    b0_element = 16'h0100; b1_element = 16'h0100; b2_element = 16'h0100; b3_element = 16'h0100;
    b_element_ready = 1'b1;
    n = 0;
    while (!m_element_requested && n < 50) begin tick(); n++; end
    tick();
    m_element = 16'h0500;
    m_element_ready = 1'b1;
    tick();
    m_element_ready = 1'b0;
    tick();
    clear_n = 1'b0;
    b_element_ready = 1'b0;
    tick();
    check("midreset_outputs", {1'b0, m_element_requested, out_memory_enable, out_memory_write,
                               out_memory_address, out_element, busy, done}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    clear_n = 1'b1;
    set_taps(16'h0100, 16'h0100, 16'h0000, 16'h0000);
    add_x(16'h0100);
    add_x(16'h0200);
    run_vector(1'b0, 1, -1, OPT_NONE);
    check("fresh_y0", 32'(wr_log[0]), 32'h0100);
    check("fresh_y1", 32'(wr_log[1]), 32'h0300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
